// File: rtl/leaves_pkg.sv
// Shared types and derived widths for the banked leaf memory sequencer.
package leaves_pkg;

    localparam int unsigned DATA_WIDTH = 11;
    localparam int unsigned IDX_WIDTH  = 9;
    localparam int unsigned LEAF_SIZE  = 8;
    localparam int unsigned PATCH_SIZE = 5;
    localparam int unsigned NUM_LEAVES = 64;
    localparam int unsigned LEAF_ADDRW = $clog2(NUM_LEAVES);
    localparam int unsigned SLOT_W     = $clog2(LEAF_SIZE);
    localparam int unsigned PATCH_W    = PATCH_SIZE * DATA_WIDTH;
    localparam int unsigned WORD_W     = PATCH_W + IDX_WIDTH;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_LOAD   = 2'd1,
        ST_DONE   = 2'd2,
        ST_ACTIVE = 2'd3
    } state_e;

    typedef struct packed {
        logic [IDX_WIDTH-1:0] idx;
        logic [PATCH_W-1:0]   patch;
    } leaf_entry_t;

endpackage

// File: rtl/leaf_write_counter.sv
// Slot/leaf write position counter: slot advances per entry, leaf advances on slot wrap.
module leaf_write_counter
    import leaves_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  clr_i,
    input  logic                  en_i,
    output logic [SLOT_W-1:0]     slot_o,
    output logic [LEAF_ADDRW-1:0] leaf_o,
    output logic                  last_o
);

    logic [SLOT_W-1:0]     slot_q;
    logic [LEAF_ADDRW-1:0] leaf_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            slot_q <= '0;
            leaf_q <= '0;
        end else if (clr_i) begin
            slot_q <= '0;
            leaf_q <= '0;
        end else if (en_i) begin
            if (slot_q == SLOT_W'(LEAF_SIZE - 1)) begin
                slot_q <= '0;
                leaf_q <= leaf_q + LEAF_ADDRW'(1);
            end else begin
                slot_q <= slot_q + SLOT_W'(1);
            end
        end
    end

    assign slot_o = slot_q;
    assign leaf_o = leaf_q;
    assign last_o = (leaf_q == LEAF_ADDRW'(NUM_LEAVES - 1)) &&
                    (slot_q == SLOT_W'(LEAF_SIZE - 1));

endmodule

// File: rtl/leaves_mem_sched.sv
// Leaf memory sequencer: streams a full reload bank-by-bank, then arbitrates
// the two search read ports onto memory ports 0 and 1.
module leaves_mem_sched
    import leaves_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  load_start,
    input  logic                  load_valid,
    output logic                  load_ready,
    input  logic [WORD_W-1:0]     load_data,
    output logic                  load_done,
    output logic                  busy,
    output logic                  active,
    input  logic                  rd0_req,
    input  logic [LEAF_ADDRW-1:0] rd0_addr,
    output logic                  rd0_gnt,
    output logic                  rd0_valid,
    input  logic                  rd1_req,
    input  logic [LEAF_ADDRW-1:0] rd1_addr,
    output logic                  rd1_gnt,
    output logic                  rd1_valid,
    output logic [LEAF_SIZE-1:0]  mem_csb0,
    output logic [LEAF_SIZE-1:0]  mem_web0,
    output logic [LEAF_ADDRW-1:0] mem_addr0,
    output logic [WORD_W-1:0]     mem_wleaf0,
    output logic                  mem_csb1,
    output logic [LEAF_ADDRW-1:0] mem_addr1
);

    state_e                state_q, state_d;
    logic                  load_done_q, load_done_d;
    logic                  rd0_valid_q, rd1_valid_q;
    logic                  accept, cnt_clr, cnt_last;
    logic [SLOT_W-1:0]     slot_cnt;
    logic [LEAF_ADDRW-1:0] leaf_cnt;
    leaf_entry_t           wentry;

    assign accept  = load_valid && (state_q == ST_LOAD);
    assign cnt_clr = load_start && ((state_q == ST_IDLE) || (state_q == ST_ACTIVE));

    leaf_write_counter u_cnt (
        .clk    (clk),
        .rst_n  (rst_n),
        .clr_i  (cnt_clr),
        .en_i   (accept),
        .slot_o (slot_cnt),
        .leaf_o (leaf_cnt),
        .last_o (cnt_last)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            load_done_q <= 1'b0;
            rd0_valid_q <= 1'b0;
            rd1_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            load_done_q <= load_done_d;
            rd0_valid_q <= rd0_gnt;
            rd1_valid_q <= rd1_gnt;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:   if (load_start) state_d = ST_LOAD;
            ST_LOAD:   if (accept && cnt_last) state_d = ST_DONE;
            ST_DONE:   state_d = ST_ACTIVE;
            ST_ACTIVE: if (load_start) state_d = ST_LOAD;
            default:   state_d = ST_IDLE;
        endcase
        load_done_d = (state_d == ST_DONE);
    end

    // load_start beats a same-cycle read request so the reload starts cleanly.
    assign rd0_gnt = rd0_req && (state_q == ST_ACTIVE) && !load_start;
    assign rd1_gnt = rd1_req && (state_q == ST_ACTIVE) && !load_start;

    always_comb begin
        mem_csb0  = '1;
        mem_web0  = '1;
        mem_addr0 = '0;
        if (accept) begin
            mem_csb0  = ~(LEAF_SIZE'(1) << slot_cnt);
            mem_web0  = ~(LEAF_SIZE'(1) << slot_cnt);
            mem_addr0 = leaf_cnt;
        end else if (rd0_gnt) begin
            mem_csb0  = '0;
            mem_addr0 = rd0_addr;
        end
    end

    assign wentry     = leaf_entry_t'(load_data);
    assign mem_wleaf0 = wentry;
    assign mem_csb1   = !rd1_gnt;
    assign mem_addr1  = rd1_gnt ? rd1_addr : '0;

    assign load_ready = (state_q == ST_LOAD);
    assign busy       = (state_q == ST_LOAD);
    assign active     = (state_q == ST_ACTIVE);
    assign load_done  = load_done_q;
    assign rd0_valid  = rd0_valid_q;
    assign rd1_valid  = rd1_valid_q;

endmodule
